// File: rtl/rv_pkg.sv
// Shared RV front-end definitions: data width, NOP encoding, fetch queue entry.
package rv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Clear the two byte-offset bits so an address always names a whole word.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Flushable first-word-fall-through FIFO of fetch entries; flush wins over push/pop.
module fetch_queue
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  fetch_entry_t             din,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [AW-1:0] PTR_MASK = AW'(DEPTH - 1);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap by power-of-two masking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr + AW'(1)) & PTR_MASK;
      if (do_pop)  rd_ptr <= (rd_ptr + AW'(1)) & PTR_MASK;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, credit-limited imem requests,
// wrong-path squashing on redirect, and queued delivery to IF/ID.
// Optional macro FETCH_PERF_CNT_EN adds the perf_bubble_cnt output.
module fetch_unit
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int unsigned     QUEUE_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [XLEN-1:0]  imem_req_addr,
  input  logic             imem_resp_valid,
  input  logic [XLEN-1:0]  imem_resp_data,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  input  logic             stall,
  output logic             id_valid,
  output logic [XLEN-1:0]  id_instr,
  output logic [XLEN-1:0]  id_pc,
  output logic [XLEN-1:0]  id_pc_plus4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]      perf_bubble_cnt
`endif
);

  localparam int unsigned AW = $clog2(QUEUE_DEPTH);
  localparam int unsigned OW = AW + 1;
  localparam int unsigned SW = AW + 2;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   drop_cnt;

  fetch_entry_t    q_head;
  fetch_entry_t    q_din;
  logic [OW-1:0]   q_count;
  logic            q_empty;
  logic            q_full;

  logic            pop;
  logic            req_fire;
  logic            resp_drop;
  logic            resp_keep;
  logic            push;
  logic [SW-1:0]   credit_used;

  assign pop         = !q_empty && !stall;
  assign credit_used = SW'(outstanding) + SW'(q_count) - SW'(pop);

  // Requests are held off in reset, on redirect, and when all queue slots are spoken for.
  assign imem_req_valid = rst_n && !redirect_valid && (credit_used < SW'(QUEUE_DEPTH));
  assign imem_req_addr  = word_align(fetch_pc);
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_drop = (drop_cnt != '0);
  assign resp_keep = imem_resp_valid && !resp_drop && !redirect_valid;
  assign push      = resp_keep && (!q_full || pop);
  assign q_din     = '{instr: imem_resp_data, pc: resp_pc};

  // PC, in-flight and squash bookkeeping; redirect overrides everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= word_align(RESET_PC);
      resp_pc     <= word_align(RESET_PC);
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= word_align(redirect_pc);
      resp_pc     <= word_align(redirect_pc);
      outstanding <= outstanding - OW'(imem_resp_valid);
      drop_cnt    <= outstanding - OW'(imem_resp_valid);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
      if (push)     resp_pc  <= resp_pc + XLEN'(4);
      outstanding <= outstanding + OW'(req_fire) - OW'(imem_resp_valid);
      if (imem_resp_valid && resp_drop) drop_cnt <= drop_cnt - OW'(1);
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (q_din),
    .pop   (pop),
    .flush (redirect_valid),
    .head  (q_head),
    .count (q_count),
    .empty (q_empty),
    .full  (q_full)
  );

  // An empty queue presents a NOP at the PC the next kept response will carry.
  assign id_valid    = !q_empty;
  assign id_instr    = q_empty ? NOP_INSTR : q_head.instr;
  assign id_pc       = q_empty ? resp_pc : q_head.pc;
  assign id_pc_plus4 = id_pc + XLEN'(4);

`ifdef FETCH_PERF_CNT_EN
  // Saturating count of cycles where decode could accept but nothing is ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_bubble_cnt <= '0;
    end else if (!id_valid && !stall && (perf_bubble_cnt != 32'hFFFF_FFFF)) begin
      perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model, scoreboard of
// expected IF/ID outputs, and a table of redirect scenarios.
module tb_fetch_unit;
  import rv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int unsigned QD     = 4;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_bubble_cnt;
`endif

  fetch_unit #(
    .RESET_PC    (RST_PC),
    .QUEUE_DEPTH (QD)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .stall           (stall),
    .id_valid        (id_valid),
    .id_instr        (id_instr),
    .id_pc           (id_pc),
    .id_pc_plus4     (id_pc_plus4)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    int          lat;
    bit          toggle;
    int          stall_len;
    int          want_out;
    bit          redir_stall;
    logic [31:0] target;
    logic [31:0] exp_first;
    logic [31:0] exp_second;
  } vec_t;

  mreq_t       mq[$];
  logic [31:0] sb[$];

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          lat   = 1;
  bit          toggle = 1'b0;
  int          max_sb = 0;
  int          full_viol = 0;
  logic [31:0] exp_next;

  logic        s_rv, s_idv, s_fire;
  logic [31:0] s_ra, s_idpc, s_idi, s_idp4;
  bit          p_hold;
  logic [31:0] p_pc, p_instr;

  function automatic logic [31:0] memdata(input logic [31:0] a);
    return a ^ 32'hC3C3_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    stall           = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    mq.delete();
    sb.delete();
    exp_next = RST_PC;
    p_hold   = 1'b0;
    cyc      = 0;
    #1;
    chk("rst_async_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_async_id_valid", 32'(id_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_req_addr", imem_req_addr, RST_PC);
    chk("rst_id_instr", id_instr, 32'h0000_0013);
    chk("rst_id_pc", id_pc, RST_PC);
    chk("rst_id_pc_plus4", id_pc_plus4, RST_PC + 32'd4);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_cnt", perf_bubble_cnt, 32'd0);
`endif
    rst_n = 1'b1;
  endtask

  // One clock: drive memory, sample at negedge, check, then update models at posedge.
  task automatic cycle();
    mreq_t r;
    imem_req_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = memdata(mq[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
    @(negedge clk);
    s_rv   = imem_req_valid;
    s_ra   = imem_req_addr;
    s_idv  = id_valid;
    s_idpc = id_pc;
    s_idi  = id_instr;
    s_idp4 = id_pc_plus4;
    if (p_hold) begin
      chk("stall_hold_pc", s_idpc, p_pc);
      chk("stall_hold_instr", s_idi, p_instr);
    end
    if (redirect_valid) chk("no_req_on_redirect", 32'(s_rv), 32'd0);
    if (s_idv && !stall) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL id_extra: got pc %h want no valid entry", s_idpc);
      end else begin
        chk("id_pc", s_idpc, sb[0]);
        chk("id_instr", s_idi, memdata(sb[0]));
        chk("id_pc_plus4", s_idp4, sb[0] + 32'd4);
        void'(sb.pop_front());
      end
    end
    if (dut.resp_keep && dut.q_full) full_viol++;
    s_fire = s_rv && imem_req_ready;
    if (s_fire) chk("req_addr_seq", s_ra, exp_next);
    p_hold  = s_idv && stall && !redirect_valid;
    p_pc    = s_idpc;
    p_instr = s_idi;
    @(posedge clk);
    if (imem_resp_valid) void'(mq.pop_front());
    if (redirect_valid) begin
      sb.delete();
      exp_next = redirect_pc & ~32'h3;
    end
    if (s_fire) begin
      r.addr = s_ra;
      r.due  = cyc + lat;
      mq.push_back(r);
      sb.push_back(exp_next);
      exp_next = exp_next + 32'd4;
    end
    if (sb.size() > max_sb) max_sb = sb.size();
    cyc++;
    #1;
  endtask

  vec_t vec[6];

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          nacc, id_k, nvalid;
    bit          got_id, found;
    logic [31:0] a0, a1, id0, idp4;

    //          lat tog stl out rst target         first          second
    vec[0] = '{1, 1'b0, 5, 0, 1'b0, 32'h0000_2000, 32'h0000_2000, 32'h0000_2004};
    vec[1] = '{1, 1'b1, 0, 0, 1'b0, 32'h0000_0800, 32'h0000_0800, 32'h0000_0804};
    vec[2] = '{3, 1'b1, 0, 2, 1'b0, 32'h0000_2000, 32'h0000_2000, 32'h0000_2004};
    vec[3] = '{1, 1'b0, 0, 0, 1'b1, 32'h0000_0040, 32'h0000_0040, 32'h0000_0044};
    vec[4] = '{1, 1'b0, 0, 0, 1'b0, 32'h0000_0043, 32'h0000_0040, 32'h0000_0044};
    vec[5] = '{1, 1'b0, 0, 0, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};

    // Startup: first request at RESET_PC, first instruction two cycles later.
    lat = 1;
    toggle = 1'b0;
    do_reset();
    cycle();
    chk("start_c1_req_valid", 32'(s_rv), 32'd1);
    chk("start_c1_req_addr", s_ra, RST_PC);
    chk("start_c1_id_valid", 32'(s_idv), 32'd0);
    cycle();
    chk("start_c2_id_valid", 32'(s_idv), 32'd0);
    cycle();
    chk("start_c3_id_valid", 32'(s_idv), 32'd1);
    chk("start_c3_id_pc", s_idpc, 32'h0000_0100);
    cycle();
    chk("start_c4_id_pc", s_idpc, 32'h0000_0104);
    cycle();
    chk("start_c5_id_pc", s_idpc, 32'h0000_0108);
    nvalid = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (s_idv) nvalid++;
    end
    chk("throughput_valid_cycles", 32'(nvalid), 32'd10);

    // Redirect scenarios, each starting from a fresh reset.
    for (int i = 0; i < 6; i++) begin
      lat    = vec[i].lat;
      toggle = vec[i].toggle;
      do_reset();
      repeat (8) cycle();
      if (vec[i].stall_len > 0) begin
        stall = 1'b1;
        repeat (vec[i].stall_len) cycle();
        stall = 1'b0;
        repeat (4) cycle();
      end
      if (vec[i].want_out > 0) begin
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
          if (mq.size() == vec[i].want_out) found = 1'b1;
          else cycle();
        end
        chk("reach_outstanding", 32'(found), 32'd1);
      end
      redirect_valid = 1'b1;
      redirect_pc    = vec[i].target;
      stall          = vec[i].redir_stall;
      cycle();
      redirect_valid = 1'b0;
      stall          = 1'b0;
      nacc = 0;
      got_id = 1'b0;
      id_k = 0;
      a0 = '0;
      a1 = '0;
      id0 = '0;
      idp4 = '0;
      for (int k = 1; k <= 30; k++) begin
        cycle();
        if (k == 1 && lat == 1 && !toggle) begin
          chk("redir_r1_id_valid", 32'(s_idv), 32'd0);
          chk("redir_r1_req_valid", 32'(s_rv), 32'd1);
          chk("redir_r1_req_addr", s_ra, vec[i].exp_first);
        end
        if (s_fire) begin
          if (nacc == 0) a0 = s_ra;
          else if (nacc == 1) a1 = s_ra;
          nacc++;
        end
        if (s_idv && !got_id) begin
          got_id = 1'b1;
          id0    = s_idpc;
          idp4   = s_idp4;
          id_k   = k;
        end
      end
      chk("redir_first_addr", a0, vec[i].exp_first);
      chk("redir_second_addr", a1, vec[i].exp_second);
      chk("redir_first_id_pc", id0, vec[i].exp_first);
      chk("redir_first_id_pc_plus4", idp4, vec[i].exp_second);
      if (lat == 1 && !toggle) chk("redir_target_at_id_cycle", 32'(id_k), 32'd3);
    end

    chk("max_inflight_le_depth", 32'(max_sb <= QD), 32'd1);
    chk("push_into_full_queue", 32'(full_viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
